// File: rtl/sync_debounce_bank.sv
// sync_debounce_bank
//   Multi-channel input conditioner placed between board pins (buttons,
//   switches, external strobes) and clk-domain logic. Each channel runs
//   async_in -> SYNC_STAGES flop chain -> optional debounce filter -> level_out.
//   Single-cycle rise and fall pulses are registered and line up with the
//   cycle in which level_out changes.
//
//   Build option: define SYNC_DEBOUNCE_EN to include the per-channel debounce
//   counters. Without it the block acts as if DEBOUNCE_CYCLES == 1, and
//   level_out follows the synchronized input every cycle.
//
// Ports
//   clk         in   1         clock, all flops posedge
//   reset_n     in   1         synchronous active-low reset
//   async_in    in   CHANNELS  asynchronous raw inputs
//   level_out   out  CHANNELS  synchronized (and debounced) level, registered
//   rise_pulse  out  CHANNELS  one-cycle pulse in the first cycle level_out[i] reads 1
//   fall_pulse  out  CHANNELS  one-cycle pulse in the first cycle level_out[i] reads 0
//   any_change  out  1         OR of all rise/fall pulses, combinational from registers
module sync_debounce_bank #(
  parameter int unsigned CHANNELS        = 4,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] async_in,
  output logic [CHANNELS-1:0] level_out,
  output logic [CHANNELS-1:0] rise_pulse,
  output logic [CHANNELS-1:0] fall_pulse,
  output logic                any_change
);

  // Reject parameter sets the structure below cannot build.
  if (CHANNELS < 1 || SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_cfg_check
    $error("sync_debounce_bank: illegal parameter set");
  end

  logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q, sync_d;
  logic [CHANNELS-1:0]                  s;
  logic [CHANNELS-1:0]                  level_q, level_d;
  logic [CHANNELS-1:0]                  rise_q, rise_d;
  logic [CHANNELS-1:0]                  fall_q, fall_d;
  logic [CHANNELS-1:0]                  update;

  // Synchronizer chain: stage 0 samples the pin, the last stage is s.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
  end

  assign s = sync_q[SYNC_STAGES-1];

`ifdef SYNC_DEBOUNCE_EN
  localparam int unsigned   CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CHANNELS-1:0][CNT_W-1:0] cnt_q, cnt_d;

  // Accept a new level only after DEBOUNCE_CYCLES consecutive mismatching samples.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    update  = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      if (s[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        level_d[i] = s[i];
        cnt_d[i]   = '0;
        update[i]  = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Debounce counters.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  // No filtering: the level tracks s one cycle later.
  always_comb begin
    level_d = s;
    update  = s ^ level_q;
  end
`endif

  // Pulses are derived from the same accept decision as the level update.
  always_comb begin
    rise_d = update & s;
    fall_d = update & ~s;
  end

  // Synchronizer, level and pulse registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q  <= '0;
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
    end else begin
      sync_q  <= sync_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_out  = level_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign any_change = |(rise_q | fall_q);

endmodule

// File: tb/tb_sync_debounce_bank.sv
// Bench for sync_debounce_bank. A reference model pushes the expected outputs
// of every clock edge into a scoreboard queue; a negedge monitor pops and
// compares them. Directed scenario tasks add latency/pulse checks derived
// directly from the expected timing.
module tb_sync_debounce_bank;

  localparam int unsigned CH   = 4;
  localparam int unsigned SYNC = 2;
  localparam int unsigned DEBC = 4;
`ifdef SYNC_DEBOUNCE_EN
  localparam int DEB = int'(DEBC);
`else
  localparam int DEB = 1;
`endif
  // Edge index (capture edge = 1) after which level_out changes.
  localparam int LAT = int'(SYNC) + DEB;

  typedef struct packed {
    logic [CH-1:0] lvl;
    logic [CH-1:0] rise;
    logic [CH-1:0] fall;
    logic          any;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [CH-1:0] async_in;
  logic [CH-1:0] level_out;
  logic [CH-1:0] rise_pulse;
  logic [CH-1:0] fall_pulse;
  logic          any_change;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];

  sync_debounce_bank #(
    .CHANNELS       (CH),
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEBC)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .async_in  (async_in),
    .level_out (level_out),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .any_change(any_change)
  );

  always #5 clk = ~clk;

  // Reference model: a new level is taken once the last DEB samples of the
  // synchronized input all disagree with the current level.
  logic [CH-1:0] m_sync [SYNC];
  logic [CH-1:0] m_hist [DEB];
  logic [CH-1:0] m_lvl, m_rise, m_fall;

  always @(posedge clk) begin : model
    logic [CH-1:0] s_now;
    logic          stable;
    exp_t          e;
    if (!reset_n) begin
      for (int j = 0; j < int'(SYNC); j++) m_sync[j] = '0;
      for (int k = 0; k < DEB; k++) m_hist[k] = '0;
      m_lvl  = '0;
      m_rise = '0;
      m_fall = '0;
    end else begin
      s_now = m_sync[SYNC-1];
      for (int k = DEB - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = s_now;
      m_rise = '0;
      m_fall = '0;
      for (int c = 0; c < int'(CH); c++) begin
        stable = 1'b1;
        for (int k = 0; k < DEB; k++)
          if (m_hist[k][c] == m_lvl[c]) stable = 1'b0;
        if (stable) begin
          if (s_now[c]) m_rise[c] = 1'b1;
          else          m_fall[c] = 1'b1;
          m_lvl[c] = s_now[c];
        end
      end
      for (int j = int'(SYNC) - 1; j > 0; j--) m_sync[j] = m_sync[j-1];
      m_sync[0] = async_in;
    end
    e.lvl  = m_lvl;
    e.rise = m_rise;
    e.fall = m_fall;
    e.any  = |(m_rise | m_fall);
    sb_q.push_back(e);
  end

  // Scoreboard monitor, sampling on the inactive edge.
  always @(negedge clk) begin : monitor
    exp_t e;
    exp_t got;
    got = {level_out, rise_pulse, fall_pulse, any_change};
    n_checks++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty t=%0t got=%h", $time, got);
    end else begin
      e = sb_q.pop_front();
      if (got !== e) begin
        n_fail++;
        $display("FAIL scoreboard t=%0t got lvl=%b rise=%b fall=%b any=%b exp lvl=%b rise=%b fall=%b any=%b",
                 $time, got.lvl, got.rise, got.fall, got.any, e.lvl, e.rise, e.fall, e.any);
      end
    end
  end

  task automatic settle(input logic [CH-1:0] val);
    @(negedge clk);
    async_in = val;
    repeat (LAT + 2) @(posedge clk);
  endtask

  // Spec scenario 1: reset holds outputs at 0, then a full-latency rise.
  task automatic test_reset();
    logic [CH-1:0] exp_lvl, exp_rise;
    reset_n  = 1'b0;
    async_in = 4'hF;
    repeat (3) begin
      @(posedge clk); #1;
      n_checks++;
      if ({level_out, rise_pulse, fall_pulse, any_change} !== 13'd0) begin
        n_fail++;
        $display("FAIL reset_outputs got lvl=%b rise=%b fall=%b any=%b exp all 0",
                 level_out, rise_pulse, fall_pulse, any_change);
      end
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int n = 1; n <= LAT + 1; n++) begin
      @(posedge clk); #1;
      exp_lvl  = (n >= LAT) ? 4'hF : 4'h0;
      exp_rise = (n == LAT) ? 4'hF : 4'h0;
      n_checks++;
      if (level_out !== exp_lvl || rise_pulse !== exp_rise || any_change !== (n == LAT)) begin
        n_fail++;
        $display("FAIL reset_release edge=%0d got lvl=%b rise=%b any=%b exp lvl=%b rise=%b any=%b",
                 n, level_out, rise_pulse, any_change, exp_lvl, exp_rise, (n == LAT));
      end
    end
  endtask

  // Spec scenario 2: a 3-sample high on ch0 is filtered unless DEB <= 3.
  task automatic test_glitch();
    int rises = 0;
    int falls = 0;
    int exp_n;
    settle(4'h0);
    @(negedge clk);
    async_in[0] = 1'b1;
    for (int i = 0; i < 3 + LAT + 3; i++) begin
      @(posedge clk); #1;
      rises += int'(rise_pulse[0]);
      falls += int'(fall_pulse[0]);
      if (i == 2) begin
        @(negedge clk);
        async_in[0] = 1'b0;
      end
    end
    exp_n = (3 >= DEB) ? 1 : 0;
    n_checks++;
    if (rises !== exp_n || falls !== exp_n) begin
      n_fail++;
      $display("FAIL glitch_pulses got rises=%0d falls=%0d exp %0d each", rises, falls, exp_n);
    end
    n_checks++;
    if (level_out[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_level got %b exp 0", level_out[0]);
    end
  endtask

  // Spec scenario 3: held rise on ch0 appears at edge LAT with one pulse.
  task automatic test_rise_latency();
    int n = 0;
    int extra = 0;
    @(negedge clk);
    async_in[0] = 1'b1;
    while (level_out[0] !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    n_checks++;
    if (n !== LAT) begin
      n_fail++;
      $display("FAIL rise_latency got edge=%0d exp %0d", n, LAT);
    end
    n_checks++;
    if (rise_pulse !== 4'b0001) begin
      n_fail++;
      $display("FAIL rise_pulse_ch0 got %b exp 0001", rise_pulse);
    end
    repeat (10) begin
      @(posedge clk); #1;
      extra += int'(rise_pulse[0]) + int'(fall_pulse[0]);
    end
    n_checks++;
    if (extra !== 0) begin
      n_fail++;
      $display("FAIL rise_held_extra_pulses got %0d exp 0", extra);
    end
  endtask

  // Spec scenario 4: rise on ch1 and fall on ch2 in the same cycle.
  task automatic test_simultaneous();
    logic [CH-1:0] exp_r, exp_f;
    settle(4'b0101);
    @(negedge clk);
    async_in = 4'b0011;
    for (int n = 1; n <= LAT; n++) begin
      @(posedge clk); #1;
      exp_r = (n == LAT) ? 4'b0010 : 4'b0000;
      exp_f = (n == LAT) ? 4'b0100 : 4'b0000;
      n_checks++;
      if (rise_pulse !== exp_r || fall_pulse !== exp_f) begin
        n_fail++;
        $display("FAIL simultaneous edge=%0d got rise=%b fall=%b exp rise=%b fall=%b",
                 n, rise_pulse, fall_pulse, exp_r, exp_f);
      end
    end
    n_checks++;
    if (level_out !== 4'b0011) begin
      n_fail++;
      $display("FAIL simultaneous_level got %b exp 0011", level_out);
    end
  endtask

  // Spec scenario 5: reset while ch3 is counting discards the count.
  task automatic test_reset_mid_count();
    int n = 0;
    settle(4'h0);
    @(negedge clk);
    async_in = 4'b1000;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (level_out !== 4'h0 || rise_pulse !== 4'h0 || fall_pulse !== 4'h0) begin
      n_fail++;
      $display("FAIL midcount_reset got lvl=%b rise=%b fall=%b exp all 0",
               level_out, rise_pulse, fall_pulse);
    end
    @(negedge clk);
    reset_n = 1'b1;
    while (level_out[3] !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    n_checks++;
    if (n !== LAT || rise_pulse !== 4'b1000) begin
      n_fail++;
      $display("FAIL midcount_rerise got edge=%0d rise=%b exp edge=%0d rise=1000",
               n, rise_pulse, LAT);
    end
  endtask

  // Spec scenario 6: one-cycle input high; passes only when unfiltered.
  task automatic test_one_cycle();
    int rise_n = -1;
    int fall_n = -1;
    int pulses = 0;
    int exp_rise_n, exp_fall_n, exp_pulses;
    settle(4'h0);
    @(negedge clk);
    async_in[0] = 1'b1;
    for (int n = 1; n <= LAT + 6; n++) begin
      @(posedge clk); #1;
      if (rise_pulse[0] === 1'b1 && rise_n < 0) rise_n = n;
      if (fall_pulse[0] === 1'b1 && fall_n < 0) fall_n = n;
      pulses += int'(rise_pulse[0]) + int'(fall_pulse[0]);
      if (n == 1) begin
        @(negedge clk);
        async_in[0] = 1'b0;
      end
    end
    exp_rise_n = (DEB == 1) ? int'(SYNC) + 1 : -1;
    exp_fall_n = (DEB == 1) ? int'(SYNC) + 2 : -1;
    exp_pulses = (DEB == 1) ? 2 : 0;
    n_checks++;
    if (rise_n !== exp_rise_n || fall_n !== exp_fall_n || pulses !== exp_pulses) begin
      n_fail++;
      $display("FAIL one_cycle got rise_edge=%0d fall_edge=%0d pulses=%0d exp %0d %0d %0d",
               rise_n, fall_n, pulses, exp_rise_n, exp_fall_n, exp_pulses);
    end
  endtask

  // Random slow-toggling inputs with one reset, checked by the scoreboard.
  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      for (int c = 0; c < int'(CH); c++)
        if ($urandom_range(5) == 0) async_in[c] = ~async_in[c];
      reset_n = (i == 150) ? 1'b0 : 1'b1;
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (LAT + 2) @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_rise_latency();
    test_simultaneous();
    test_reset_mid_count();
    test_one_cycle();
    test_random();
    @(posedge clk);
    @(negedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
